// File: rtl/prng_stream_gen.sv
// Pseudo-random word generator: Fibonacci/Galois LFSR feeding a serial-to-word
// shifter, with optional per-byte AES S-box whitening and a valid/ready output.
module prng_stream_gen #(
    parameter int                LFSR_W   = 16,
    parameter int                OUT_W    = 8,
    parameter logic [LFSR_W-1:0] FIB_TAPS = 16'hD008,
    parameter logic [LFSR_W-1:0] GAL_TAPS = 16'hA011,
    parameter bit                WHITEN   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              mode,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic              seed_fixup
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_VALID
    } state_t;

    localparam int                CNT_W    = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OUT_W - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  next_lfsr;
    logic [OUT_W-1:0]   word_reg;
    logic [OUT_W-1:0]   white_word;
    logic [CNT_W-1:0]   bit_cnt;
    logic               mode_q;
    logic               step_bit;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        next_lfsr = lfsr;
        step_bit  = 1'b0;
        if (mode_q) begin
            step_bit  = lfsr[LFSR_W-1];
            next_lfsr = {lfsr[LFSR_W-2:0], 1'b0} ^ ({LFSR_W{lfsr[LFSR_W-1]}} & GAL_TAPS);
        end else begin
            step_bit  = ^(lfsr & FIB_TAPS);
            next_lfsr = {lfsr[LFSR_W-2:0], step_bit};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            lfsr       <= LFSR_W'(1);
            word_reg   <= '0;
            bit_cnt    <= '0;
            mode_q     <= 1'b0;
            seed_fixup <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A simultaneous start is dropped so the new seed is never skipped.
                    if (seed_load) begin
                        if (seed == '0) begin
                            lfsr       <= LFSR_W'(1);
                            seed_fixup <= 1'b1;
                        end else begin
                            lfsr       <= seed;
                            seed_fixup <= 1'b0;
                        end
                    end else if (start) begin
                        state   <= S_GEN;
                        mode_q  <= mode;
                        bit_cnt <= '0;
                    end
                end
                S_GEN: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else begin
                        lfsr     <= next_lfsr;
                        word_reg <= (word_reg << 1) | OUT_W'(step_bit);
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_LAST) begin
                            state <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (out_ready) begin
                        if (continuous) begin
                            state   <= S_GEN;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    generate
        if (WHITEN) begin : g_whiten
            for (genvar b = 0; b < OUT_W / 8; b++) begin : g_byte
                assign white_word[8*b +: 8] = SBOX[word_reg[8*b +: 8]];
            end
        end else begin : g_raw
            assign white_word = word_reg;
        end
    endgenerate

    assign out_valid = (state == S_VALID);
    assign busy      = (state != S_IDLE);
    assign out_data  = out_valid ? white_word : '0;

endmodule
